// File: rtl/fifo_drain_wr_if.sv
// Handshake bundle between the FIFO drain writer, its controller, the FIFO read port
// and the memory write port.
interface fifo_drain_wr_if #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 32,
    parameter int LEN_BITS  = 16
);
    logic                 start_i;
    logic [ADDR_BITS-1:0] base_addr_i;
    logic [LEN_BITS-1:0]  len_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 fifo_empty_i;
    logic [DATA_BITS-1:0] fifo_data_i;
    logic                 fifo_ren_o;
    logic                 mem_req_o;
    logic [ADDR_BITS-1:0] mem_addr_o;
    logic [DATA_BITS-1:0] mem_wdata_o;
    logic                 mem_gnt_i;

    modport slave (
        input  start_i, base_addr_i, len_i, fifo_empty_i, fifo_data_i, mem_gnt_i,
        output busy_o, done_o, fifo_ren_o, mem_req_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output start_i, base_addr_i, len_i, fifo_empty_i, fifo_data_i, mem_gnt_i,
        input  busy_o, done_o, fifo_ren_o, mem_req_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/fifo_drain_wr.sv
// Drains a fall-through FIFO into consecutive memory words over a req/gnt handshake,
// one transfer (base address + word count) per start pulse.
module fifo_drain_wr #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 32,
    parameter int LEN_BITS  = 16,
    parameter int ADDR_STEP = 4
) (
    input  logic           clk,
    input  logic           rst,
    fifo_drain_wr_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        REQ   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    logic [LEN_BITS-1:0]  rem;
    logic                 pop;
    logic                 grant;
    logic                 launch;

    // Address advance wraps naturally at 2^ADDR_BITS.
    function automatic logic [ADDR_BITS-1:0] step_addr(input logic [ADDR_BITS-1:0] a);
        return a + ADDR_BITS'(ADDR_STEP);
    endfunction

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        grant     = 1'b0;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    launch    = (bus.len_i != '0);
                    state_nxt = (bus.len_i != '0) ? FETCH : DONE;
                end
            end
            FETCH: begin
                if (!bus.fifo_empty_i) begin
                    pop       = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.mem_gnt_i) begin
                    grant     = 1'b1;
                    state_nxt = (rem == LEN_BITS'(1)) ? DONE : FETCH;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            addr  <= '0;
            wdata <= '0;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                addr <= bus.base_addr_i;
                rem  <= bus.len_i;
            end
            if (pop) begin
                wdata <= bus.fifo_data_i;
            end
            if (grant) begin
                addr <= step_addr(addr);
                rem  <= rem - LEN_BITS'(1);
            end
        end
    end

    assign bus.busy_o      = (state != IDLE);
    assign bus.done_o      = (state == DONE);
    assign bus.fifo_ren_o  = pop;
    assign bus.mem_req_o   = (state == REQ);
    assign bus.mem_addr_o  = addr;
    assign bus.mem_wdata_o = wdata;
endmodule

// File: tb/tb_fifo_drain_wr.sv
// Scoreboard bench for fifo_drain_wr: a FIFO/memory environment model, directed
// scenarios plus randomized transfers checked against expected (addr, data) writes.
module tb_fifo_drain_wr;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_drain_wr_if #(.DATA_BITS(DW), .ADDR_BITS(AW), .LEN_BITS(LW)) bus ();

    fifo_drain_wr #(
        .DATA_BITS(DW), .ADDR_BITS(AW), .LEN_BITS(LW), .ADDR_STEP(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    wr_t           exp_q[$];
    logic [DW-1:0] fifo_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, pops = 0, grants = 0;
    int gnt_wait = 0, wait_ctr = 0;
    bit gnt_rand = 0, stall_rand = 0;
    logic          prev_hold = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Environment: FIFO head presentation and memory grant policy.
    always @(posedge clk) begin
        #1;
        bus.fifo_empty_i = (fifo_q.size() == 0) || (stall_rand && $urandom_range(0, 2) == 0);
        bus.fifo_data_i  = bus.fifo_empty_i ? DW'($urandom) : fifo_q[0];
        if (!bus.mem_req_o) begin
            bus.mem_gnt_i = 1'($urandom_range(0, 1));
            wait_ctr      = 0;
        end else if (gnt_rand) begin
            bus.mem_gnt_i = 1'($urandom_range(0, 1));
        end else if (wait_ctr < gnt_wait) begin
            bus.mem_gnt_i = 1'b0;
            wait_ctr++;
        end else begin
            bus.mem_gnt_i = 1'b1;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (!rst) begin
            if (bus.fifo_ren_o) begin
                pops++;
                check("pop_when_empty", bus.fifo_empty_i, 0);
                check("pop_in_req", bus.mem_req_o, 0);
                if (!bus.fifo_empty_i && fifo_q.size() != 0) void'(fifo_q.pop_front());
            end
            if (bus.mem_req_o) begin
                if (prev_hold) begin
                    check("addr_stable", bus.mem_addr_o, prev_addr);
                    check("wdata_stable", bus.mem_wdata_o, prev_data);
                end
                if (bus.mem_gnt_i) begin
                    grants++;
                    if (exp_q.size() == 0) begin
                        check("extra_write", bus.mem_gnt_i, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", bus.mem_addr_o, e.addr);
                        check("wr_data", bus.mem_wdata_o, e.data);
                    end
                end
            end
            prev_hold = bus.mem_req_o && !bus.mem_gnt_i;
            prev_addr = bus.mem_addr_o;
            prev_data = bus.mem_wdata_o;
            if (bus.start_i && !bus.busy_o) start_cyc = cyc;
            if (bus.done_o) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_writes_left", exp_q.size(), 0);
            end
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic start_pulse(input logic [AW-1:0] base, input int len);
        @(posedge clk); #1;
        bus.start_i     = 1'b1;
        bus.base_addr_i = base;
        bus.len_i       = LW'(len);
        @(posedge clk); #1;
        bus.start_i     = 1'b0;
        bus.base_addr_i = AW'($urandom);
        bus.len_i       = LW'($urandom);
    endtask

    task automatic wait_done(input int d0, input int max_cyc, input bit poke);
        int n = 0;
        while (done_cnt == d0 && n < max_cyc) begin
            @(negedge clk); #1;
            n++;
            if (poke && n == 3) begin
                bus.start_i     = 1'b1;
                bus.base_addr_i = AW'($urandom);
                bus.len_i       = LW'(5);
            end
            if (poke && n == 4) bus.start_i = 1'b0;
        end
        bus.start_i = 1'b0;
        check("done_seen", done_cnt - d0, 1);
    endtask

    task automatic run_xfer(input logic [AW-1:0] base, input int len, input bit poke,
                            output int lat);
        int d0, p0, g0;
        logic [DW-1:0] w;
        for (int i = 0; i < len; i++) begin
            w = DW'($urandom);
            fifo_q.push_back(w);
            exp_q.push_back({base + AW'(4 * i), w});
        end
        d0 = done_cnt; p0 = pops; g0 = grants;
        start_pulse(base, len);
        wait_done(d0, 400, poke);
        lat = done_cyc - start_cyc;
        check("pop_count", pops - p0, len);
        check("grant_count", grants - g0, len);
        @(negedge clk); #1;
        check("busy_after_done", bus.busy_o, 0);
    endtask

    initial begin
        int lat, d0, p0, g0, len;
        logic [DW-1:0] w;
        rst = 1'b1;
        bus.start_i = 1'b0; bus.base_addr_i = '0; bus.len_i = '0;
        bus.fifo_empty_i = 1'b1; bus.fifo_data_i = '0; bus.mem_gnt_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy_o, 0);
        check("rst_done", bus.done_o, 0);
        check("rst_ren", bus.fifo_ren_o, 0);
        check("rst_req", bus.mem_req_o, 0);
        check("rst_addr", bus.mem_addr_o, 0);
        check("rst_wdata", bus.mem_wdata_o, 0);
        #1 rst = 1'b0;

        // Four words, grant always available.
        run_xfer(32'h1000, 4, 0, lat);
        check("t1_latency", lat, 9);

        // Zero-length transfer.
        run_xfer(32'h5000, 0, 0, lat);
        check("t2_latency", lat, 1);

        // Grant withheld three cycles per word, with an ignored start mid-transfer.
        gnt_wait = 3;
        run_xfer(32'h0000_0100, 2, 1, lat);
        gnt_wait = 0;

        // FIFO empty for five FETCH cycles, then one word arrives.
        w = DW'($urandom);
        exp_q.push_back({32'h4000, w});
        d0 = done_cnt; p0 = pops; g0 = grants;
        start_pulse(32'h4000, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("t4_no_pop", bus.fifo_ren_o, 0);
            check("t4_busy", bus.busy_o, 1);
        end
        fifo_q.push_back(w);
        @(negedge clk); #1;
        check("t4_pop_next", bus.fifo_ren_o, 1);
        wait_done(d0, 100, 0);
        check("t4_pops", pops - p0, 1);
        check("t4_grants", grants - g0, 1);

        // Address wrap.
        run_xfer(32'hFFFF_FFFC, 2, 0, lat);

        // Reset in REQ mid-transfer, then a fresh one-word transfer.
        gnt_wait = 3;
        for (int i = 0; i < 3; i++) begin
            w = DW'($urandom);
            fifo_q.push_back(w);
            exp_q.push_back({32'h3000 + AW'(4 * i), w});
        end
        start_pulse(32'h3000, 3);
        for (int n = 0; n < 50 && !bus.mem_req_o; n++) begin
            @(negedge clk); #1;
        end
        check("t6_reached_req", bus.mem_req_o, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        fifo_q.delete();
        gnt_wait = 0;
        @(negedge clk);
        check("t6_busy", bus.busy_o, 0);
        check("t6_req", bus.mem_req_o, 0);
        check("t6_ren", bus.fifo_ren_o, 0);
        check("t6_done", bus.done_o, 0);
        check("t6_addr", bus.mem_addr_o, 0);
        check("t6_wdata", bus.mem_wdata_o, 0);
        run_xfer(32'h2000, 1, 0, lat);
        check("t6_latency", lat, 3);

        // Randomized transfers with random grants and FIFO stalls.
        gnt_rand = 1;
        for (int t = 0; t < 25; t++) begin
            stall_rand = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 6);
            run_xfer(AW'($urandom), len, (len >= 2) && ($urandom_range(0, 1) == 1), lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
